// File: rtl/piezo_tune_if.sv
// Handshake bundle between the piezo tune sequencer, the start/status logic and
// the external duration counter.
interface piezo_tune_if;
    logic       go;
    logic       note_over;
    logic       clr;
    logic       en;
    logic [7:0] note_dur;
    logic       piezo;
    logic       piezo_n;
    logic       busy;
    logic       done;

    modport master (
        input  go, note_over,
        output clr, en, note_dur, piezo, piezo_n, busy, done
    );

    modport slave (
        output go, note_over,
        input  clr, en, note_dur, piezo, piezo_n, busy, done
    );
endinterface

// File: rtl/piezo_tune_seq.sv
// Piezo melody sequencer: walks a fixed note ROM, drives the duration counter and
// generates the piezo square wave. Define PIEZO_REPEAT_EN to loop while go is held.
module piezo_tune_seq #(
    parameter int TICK_CNT  = 500000,
    parameter int NUM_NOTES = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    piezo_tune_if.master bus
);

    localparam int IDX_W  = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
    localparam int TICK_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NOTES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CNT - 1);
`ifdef PIEZO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [TICK_W-1:0] tick_cnt;
    logic [15:0]       freq_cnt;
    logic [15:0]       note_per;
    logic              last_note;
    logic              tick_wrap;
    logic              freq_wrap;
    logic              loop_now;
    logic              tone;

    function automatic logic [15:0] rom_per(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       rom_per = 16'd31888;
            1:       rom_per = 16'd23889;
            2:       rom_per = 16'd18961;
            3:       rom_per = 16'd15944;
            4:       rom_per = 16'd18961;
            5:       rom_per = 16'd15944;
            default: rom_per = 16'd31888;
        endcase
    endfunction

    function automatic logic [7:0] rom_dur(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       rom_dur = 8'd23;
            1:       rom_dur = 8'd23;
            2:       rom_dur = 8'd23;
            3:       rom_dur = 8'd35;
            4:       rom_dur = 8'd12;
            5:       rom_dur = 8'd70;
            default: rom_dur = 8'd23;
        endcase
    endfunction

    assign note_per  = rom_per(idx);
    assign last_note = (idx == LAST_IDX);
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign freq_wrap = (freq_cnt == note_per - 16'd1);
    // Last note with go still held wraps straight back to note 0 when looping is built in.
    assign loop_now  = REPEAT_EN && last_note && bus.go;
    assign tone      = (freq_cnt < (note_per >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.go) state_nxt = LOAD;
            LOAD: state_nxt = PLAY;
            PLAY: begin
                if (bus.note_over) begin
                    if (!last_note || loop_now) state_nxt = LOAD;
                    else                        state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            tick_cnt <= '0;
            freq_cnt <= '0;
        end else begin
            case (state)
                IDLE: idx <= '0;
                LOAD: begin
                    tick_cnt <= '0;
                    freq_cnt <= '0;
                end
                PLAY: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                    freq_cnt <= freq_wrap ? '0 : freq_cnt + 16'd1;
                    if (bus.note_over) begin
                        if (!last_note)   idx <= idx + 1'b1;
                        else if (loop_now) idx <= '0;
                    end
                end
                DONE:    idx <= '0;
                default: idx <= '0;
            endcase
        end
    end

    always_comb begin
        bus.clr      = 1'b0;
        bus.en       = 1'b0;
        bus.piezo    = 1'b0;
        bus.piezo_n  = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.note_dur = rom_dur(idx);
        case (state)
            LOAD: begin
                // The counter only loads on en, so the clear must ride with an enable.
                bus.clr  = 1'b1;
                bus.en   = 1'b1;
                bus.busy = 1'b1;
            end
            PLAY: begin
                bus.busy    = 1'b1;
                bus.en      = tick_wrap && !bus.note_over;
                bus.piezo   = tone;
                bus.piezo_n = !tone;
                bus.done    = bus.note_over && loop_now;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Directed bench for piezo_tune_seq with a behavioural duration counter attached.
// Build with PIEZO_REPEAT_EN defined to exercise the looping variant.
module tb_piezo_tune_seq;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic [7:0] dur_cnt = 8'd0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_dur [6] = '{23, 23, 23, 35, 12, 70};
    int         last_done;

    piezo_tune_if bus ();

    piezo_tune_seq #(.TICK_CNT(T), .NUM_NOTES(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural duration counter
    always @(posedge clk) begin
        if (bus.clr && bus.en) dur_cnt <= 8'd0;
        else if (bus.en)       dur_cnt <= dur_cnt + 8'd1;
    end
    assign bus.note_over = force_en ? force_val : (dur_cnt == bus.note_dur);

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered at the LOAD cycle of note k; returns at the cycle after its PLAY phase.
    task automatic run_note(input int k);
        int play, ens, dn;
        play = 0; ens = 0; dn = 0;
        chk($sformatf("load_clr%0d", k), bus.clr, 1);
        chk($sformatf("load_en%0d", k), bus.en, 1);
        chk($sformatf("load_dur%0d", k), bus.note_dur, exp_dur[k]);
        tick;
        while ((bus.piezo | bus.piezo_n) && play < exp_dur[k] * T + 100) begin
            play++;
            if (bus.en)   ens++;
            if (bus.done) dn++;
            tick;
        end
        chk($sformatf("play_len%0d", k), play, exp_dur[k] * T + 1);
        chk($sformatf("en_count%0d", k), ens, exp_dur[k]);
        last_done = dn;
    endtask

    initial begin
        int bad, hi, lo;
        bus.go = 1'b0;

        // Reset state
        tick;
        chk("rst_busy", bus.busy, 0);
        chk("rst_piezo", bus.piezo, 0);
        chk("rst_piezo_n", bus.piezo_n, 0);
        chk("rst_en", bus.en, 0);
        chk("rst_clr", bus.clr, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dur", bus.note_dur, 23);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (bus.busy || bus.piezo || bus.piezo_n || bus.en || bus.clr || bus.done ||
                bus.note_dur != 8'd23) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Stray note_over in IDLE
        force_en = 1'b1; force_val = 1'b1;
        tick;
        force_en = 1'b0; force_val = 1'b0;
        tick;
        chk("idle_over_busy", bus.busy, 0);
        chk("idle_over_clr", bus.clr, 0);
        chk("idle_over_dur", bus.note_dur, 23);

        // Full melody; go is re-asserted while busy and then held
        bus.go = 1'b1;
        tick;
        bus.go = 1'b0;
        chk("start_busy", bus.busy, 1);
        for (int k = 0; k < 6; k++) begin
            if (k == 1) bus.go = 1'b1;
            run_note(k);
`ifndef PIEZO_REPEAT_EN
            chk($sformatf("no_early_done%0d", k), last_done, 0);
`endif
        end
`ifdef PIEZO_REPEAT_EN
        chk("loop_done_pulse", last_done, 1);
        chk("loop_busy", bus.busy, 1);
        chk("loop_clr", bus.clr, 1);
        chk("loop_dur", bus.note_dur, 23);
`else
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_clr", bus.clr, 0);
        force_en = 1'b1; force_val = 1'b1;
        tick;
        force_en = 1'b0; force_val = 1'b0;
        chk("after_done_busy", bus.busy, 0);
        chk("after_done_done", bus.done, 0);
        chk("after_done_dur", bus.note_dur, 23);
        tick;
        chk("restart_clr", bus.clr, 1);
        chk("restart_busy", bus.busy, 1);
`endif
        bus.go = 1'b0;

        // Second run: notes 0..2 normally, then a stretched note 3 for waveform checks
        for (int k = 0; k < 3; k++) run_note(k);
        chk("n3_clr", bus.clr, 1);
        chk("n3_dur", bus.note_dur, 35);
        force_en = 1'b1; force_val = 1'b0;
        tick;
        hi = 0; lo = 0; bad = 0;
        while (bus.piezo && hi < 20000) begin
            if (bus.piezo_n) bad++;
            hi++;
            tick;
        end
        while (!bus.piezo && hi + lo < 40000) begin
            if (!bus.piezo_n) bad++;
            lo++;
            tick;
        end
        chk("n3_high", hi, 7972);
        chk("n3_low", lo, 7972);
        chk("n3_wrap", bus.piezo, 1);
        chk("n3_compl", bad, 0);

        // 15944 mod 50 = 44: five more cycles reach a tick-wrap cycle
        for (int i = 0; i < 5; i++) tick;
        chk("wrap_en", bus.en, 1);
        force_val = 1'b1;
        #1;
        chk("en_suppressed", bus.en, 0);
        tick;
        chk("n4_clr", bus.clr, 1);
        chk("n4_dur", bus.note_dur, 12);
        force_en = 1'b0; force_val = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        chk("n4_piezo", bus.piezo, 1);

        // Asynchronous reset mid-note
        #2 rst_n = 1'b0;
        #1;
        chk("arst_piezo", bus.piezo, 0);
        chk("arst_piezo_n", bus.piezo_n, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_en", bus.en, 0);
        chk("arst_clr", bus.clr, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_dur", bus.note_dur, 23);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        chk("post_rst_busy", bus.busy, 0);

        bus.go = 1'b1;
        tick;
        bus.go = 1'b0;
        chk("rerun_clr", bus.clr, 1);
        chk("rerun_dur", bus.note_dur, 23);
        force_en = 1'b1; force_val = 1'b0;
        tick;
        hi = 0;
        while (bus.piezo && hi < 20000) begin
            hi++;
            tick;
        end
        chk("n0_high", hi, 15944);
        chk("n0_low_n", bus.piezo_n, 1);
        force_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
